// File: rtl/child_port_arbiter_pkg.sv
// Shared definitions for the child-port arbiter: default sizes, the beat
// counter width and the arbitration state encoding.
package child_port_arbiter_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int N_REQ_DEFAULT  = 4;
  localparam int BEAT_CNT_W     = 16;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/child_port_arbiter_rr_pick.sv
// Rotating priority search: returns the first set bit of valid at or above
// ptr, wrapping from N_REQ-1 back to 0.
//   valid [N_REQ-1:0] in  : candidate requesters
//   ptr   [IDX_W-1:0] in  : index with highest priority this cycle
//   grant [N_REQ-1:0] out : one-hot winner (all zero when nothing valid)
//   idx   [IDX_W-1:0] out : binary index of the winner
//   any               out : some requester was valid
module rr_pick #(
  parameter int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int s;
    logic [IDX_W-1:0] j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    s     = 0;
    j     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // ptr + k folded back into 0..N_REQ-1; ptr is always < N_REQ
      s = int'(ptr) + k;
      if (s >= N_REQ) s = s - N_REQ;
      j = IDX_W'(s);
      if (!any && valid[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/child_port_arbiter.sv
// N-way round-robin arbiter with lock support feeding a one-entry output
// register toward the child datapath.
//   clock                       in  : rising-edge clock
//   reset                       in  : asynchronous active-low reset
//   io_in_valid  [N_REQ-1:0]    in  : per-requester valid
//   io_in_ready  [N_REQ-1:0]    out : per-requester ready (at most one high)
//   io_in_bits   [N_REQ*DATA_W] in  : requester i payload at [i*DATA_W +: DATA_W]
//   io_in_lock   [N_REQ-1:0]    in  : requester keeps the grant after this beat
//   io_out_valid                out : registered beat valid
//   io_out_ready                in  : child accepts the beat
//   io_out_bits  [DATA_W-1:0]   out : registered payload
//   io_out_src   [IDX_W-1:0]    out : requester that sourced io_out_bits
//   io_beat_count[15:0]         out : output beats accepted since reset
//
// state  | meaning
// ARB    | round-robin search from rr_ptr over all valid requesters
// LOCKED | only lock_id is granted until it sends a beat with lock=0
module child_port_arbiter
  import child_port_arbiter_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        io_in_valid,
  output logic [N_REQ-1:0]        io_in_ready,
  input  logic [N_REQ*DATA_W-1:0] io_in_bits,
  input  logic [N_REQ-1:0]        io_in_lock,
  output logic                    io_out_valid,
  input  logic                    io_out_ready,
  output logic [DATA_W-1:0]       io_out_bits,
  output logic [IDX_W-1:0]        io_out_src,
  output logic [BEAT_CNT_W-1:0]   io_beat_count
);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0] lock_id, lock_id_nxt;

  logic [N_REQ-1:0] pick_grant;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  logic [N_REQ-1:0] lock_grant;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             can_load;
  logic             xfer;
  logic [DATA_W-1:0] sel_bits;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(N_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .valid (io_in_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    lock_grant          = '0;
    lock_grant[lock_id] = 1'b1;
  end

  // LOCKED grants lock_id even while it is not valid, so nobody else can
  // slip in between beats of a locked sequence.
  assign grant     = (state == LOCKED) ? lock_grant : (pick_any ? pick_grant : '0);
  assign grant_idx = (state == LOCKED) ? lock_id : pick_idx;
  assign can_load  = !io_out_valid || io_out_ready;

  // Gated by reset so the requesters see no ready while the block is held.
  assign io_in_ready = (reset && can_load) ? grant : '0;
  assign xfer        = |(io_in_valid & io_in_ready);

  always_comb begin
    sel_bits = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) sel_bits = io_in_bits[i*DATA_W +: DATA_W];
    end
  end

  // In LOCKED grant_idx equals lock_id, so one rule covers both states.
  always_comb begin
    state_nxt   = state;
    rr_ptr_nxt  = rr_ptr;
    lock_id_nxt = lock_id;
    if (xfer) begin
      if (io_in_lock[grant_idx]) begin
        state_nxt   = LOCKED;
        lock_id_nxt = grant_idx;
      end else begin
        state_nxt  = ARB;
        rr_ptr_nxt = wrap_inc(grant_idx);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ARB;
      rr_ptr  <= '0;
      lock_id <= '0;
    end else begin
      state   <= state_nxt;
      rr_ptr  <= rr_ptr_nxt;
      lock_id <= lock_id_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_out_valid  <= 1'b0;
      io_out_bits   <= '0;
      io_out_src    <= '0;
      io_beat_count <= '0;
    end else begin
      if (io_out_valid && io_out_ready) io_beat_count <= io_beat_count + 1'b1;
      if (xfer) begin
        io_out_valid <= 1'b1;
        io_out_bits  <= sel_bits;
        io_out_src   <= grant_idx;
      end else if (io_out_ready) begin
        io_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_child_port_arbiter.sv
module tb_child_port_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_bits = '0;
  logic [N-1:0]   in_lock = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_bits;
  logic [1:0]     out_src;
  logic [15:0]    beat_count;

  int errors = 0;
  int checks = 0;

  child_port_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
    .clock         (clock),
    .reset         (reset),
    .io_in_valid   (in_valid),
    .io_in_ready   (in_ready),
    .io_in_bits    (in_bits),
    .io_in_lock    (in_lock),
    .io_out_valid  (out_valid),
    .io_out_ready  (out_ready),
    .io_out_bits   (out_bits),
    .io_out_src    (out_src),
    .io_beat_count (beat_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  lock;
    logic        oready;
    logic [31:0] d2;
    logic [3:0]  exp_ready;
    logic        exp_ovalid;
    logic [1:0]  exp_src;
    logic [31:0] exp_bits;
    logic [15:0] exp_cnt;
  } vec_t;

  // Behavioural reference: plain integers, arithmetic modulo N.
  int          m_rr, m_lock_id, m_src;
  bit          m_locked, m_ov;
  logic [31:0] m_bits;
  int          m_cnt;

  task automatic model_reset();
    m_rr = 0; m_lock_id = 0; m_locked = 0; m_ov = 0; m_bits = '0; m_src = 0; m_cnt = 0;
  endtask

  function automatic int model_pick(input logic [3:0] v);
    if (m_locked) return m_lock_id;
    for (int k = 0; k < N; k++) if (v[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  initial begin
    vec_t tv[10];
    logic [31:0] pay [4];
    int g;
    logic [3:0] exp_rdy;
    bit cl, xf;

    pay[0] = 32'hC0DE_0000; pay[1] = 32'hC0DE_0001;
    pay[2] = 32'hC0DE_0002; pay[3] = 32'hC0DE_0003;

    //            valid lock  ordy d2             ready ov src bits           cnt
    tv[0] = '{4'hF, 4'h0, 1, 32'hC0DE_0002, 4'h1, 0, 0, 32'h0,          16'd0};
    tv[1] = '{4'hF, 4'h0, 1, 32'hC0DE_0002, 4'h2, 1, 0, 32'hC0DE_0000, 16'd0};
    tv[2] = '{4'hF, 4'h0, 1, 32'hC0DE_0002, 4'h4, 1, 1, 32'hC0DE_0001, 16'd1};
    tv[3] = '{4'hF, 4'h0, 1, 32'hC0DE_0002, 4'h8, 1, 2, 32'hC0DE_0002, 16'd2};
    tv[4] = '{4'hF, 4'h0, 1, 32'hC0DE_0002, 4'h1, 1, 3, 32'hC0DE_0003, 16'd3};
    tv[5] = '{4'hF, 4'h0, 1, 32'hC0DE_0002, 4'h2, 1, 0, 32'hC0DE_0000, 16'd4};
    tv[6] = '{4'hF, 4'h4, 1, 32'hA5A5_A5A5, 4'h4, 1, 1, 32'hC0DE_0001, 16'd5};
    tv[7] = '{4'hF, 4'h0, 1, 32'h1234_5678, 4'h4, 1, 2, 32'hA5A5_A5A5, 16'd6};
    tv[8] = '{4'hF, 4'h0, 1, 32'hC0DE_0002, 4'h8, 1, 2, 32'h1234_5678, 16'd7};
    tv[9] = '{4'hF, 4'h0, 1, 32'hC0DE_0002, 4'h1, 1, 3, 32'hC0DE_0003, 16'd8};

    // Reset state, with requesters already asking
    in_valid = 4'hF;
    #2;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_bits", out_bits, 0);
    check("rst_out_src", 32'(out_src), 0);
    check("rst_beat_count", 32'(beat_count), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    tick(); tick();
    reset = 1'b1;

    // Round robin then lock sequence from req 2
    for (int k = 0; k < 10; k++) begin
      in_valid  = tv[k].valid;
      in_lock   = tv[k].lock;
      out_ready = tv[k].oready;
      in_bits   = {pay[3], tv[k].d2, pay[1], pay[0]};
      #3;
      check($sformatf("tab%0d_ready", k), 32'(in_ready), 32'(tv[k].exp_ready));
      check($sformatf("tab%0d_ovalid", k), 32'(out_valid), 32'(tv[k].exp_ovalid));
      if (tv[k].exp_ovalid) begin
        check($sformatf("tab%0d_src", k), 32'(out_src), 32'(tv[k].exp_src));
        check($sformatf("tab%0d_bits", k), out_bits, tv[k].exp_bits);
      end
      check($sformatf("tab%0d_cnt", k), 32'(beat_count), 32'(tv[k].exp_cnt));
      tick();
    end

    // Output stall for 5 cycles with everyone valid
    in_valid = 4'hF; in_lock = 4'h0; out_ready = 1'b0;
    in_bits  = {pay[3], pay[2], pay[1], pay[0]};
    for (int k = 0; k < 5; k++) begin
      #3;
      check("stall_ready", 32'(in_ready), 0);
      check("stall_ovalid", 32'(out_valid), 1);
      check("stall_src", 32'(out_src), 0);
      check("stall_bits", out_bits, 32'hC0DE_0000);
      tick();
    end
    out_ready = 1'b1;
    #3;
    check("release_ready", 32'(in_ready), 32'h2);
    check("release_bits", out_bits, 32'hC0DE_0000);
    tick();
    #3;
    check("release_src", 32'(out_src), 1);
    check("release_bits2", out_bits, 32'hC0DE_0001);
    check("release_cnt", 32'(beat_count), 10);

    // Enter LOCKED on req 3, then reset while holding a beat
    in_valid = 4'h8; in_lock = 4'h8;
    #0;
    check("lock_ready", 32'(in_ready), 32'h8);
    tick();
    in_valid = 4'h7; in_lock = 4'h0; out_ready = 1'b0;
    #3;
    check("locked_ovalid", 32'(out_valid), 1);
    check("locked_src", 32'(out_src), 3);
    check("locked_stall_ready", 32'(in_ready), 0);
    out_ready = 1'b1;
    #1;
    check("locked_only_id", 32'(in_ready), 32'h8);
    out_ready = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check("midrst_ovalid", 32'(out_valid), 0);
    check("midrst_ready", 32'(in_ready), 0);
    check("midrst_cnt", 32'(beat_count), 0);
    tick();
    reset = 1'b1;
    in_valid = 4'hF; in_lock = 4'h0; out_ready = 1'b1;
    #3;
    check("postrst_ready", 32'(in_ready), 32'h1);
    tick();
    #3;
    check("postrst_src", 32'(out_src), 0);
    tick();

    // Randomized traffic against the reference model
    reset = 1'b0;
    #1;
    reset = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      in_valid  = 4'($urandom_range(0, 15));
      in_lock   = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      in_bits   = {$urandom, $urandom, $urandom, $urandom};
      #3;
      g  = model_pick(in_valid);
      cl = !m_ov || out_ready;
      exp_rdy = (cl && g >= 0) ? 4'(1 << g) : 4'h0;
      xf = cl && g >= 0 && in_valid[g];
      check("rnd_ready", 32'(in_ready), 32'(exp_rdy));
      check("rnd_ovalid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
        check("rnd_src", 32'(out_src), 32'(m_src));
        check("rnd_bits", out_bits, m_bits);
      end
      check("rnd_cnt", 32'(beat_count), 32'(m_cnt));
      if (m_ov && out_ready) m_cnt = (m_cnt + 1) % 65536;
      if (xf) begin
        m_ov = 1; m_src = g; m_bits = in_bits[g*W +: W];
        if (in_lock[g]) begin
          m_locked = 1; m_lock_id = g;
        end else begin
          m_locked = 0; m_rr = (g + 1) % N;
        end
      end else if (out_ready) begin
        m_ov = 0;
      end
      tick();
    end

    // Beat counter wrap: 65537 beats
    reset = 1'b0;
    #1;
    reset = 1'b1;
    in_valid = 4'hF; in_lock = 4'h0; out_ready = 1'b1;
    repeat (65536) tick();
    #3;
    check("cnt_ffff", 32'(beat_count), 32'hFFFF);
    tick(); tick();
    #3;
    check("cnt_wrap", 32'(beat_count), 32'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/child_port_arbiter.md
CHILD_PORT_ARBITER -- requirements
Module: child_port_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning the number of requesters sharing the 32-bit child datapath (legal range 2..8).
REQ-002 SHALL have parameter DATA_W, default 32, meaning the payload width in bits.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port io_in_valid, input, N_REQ bits: per-requester valid.
REQ-006 SHALL have port io_in_ready, output, N_REQ bits: per-requester ready.
REQ-007 SHALL have port io_in_bits, input, N_REQ*DATA_W bits: requester i payload at bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port io_in_lock, input, N_REQ bits: requester i holds the grant after this beat.
REQ-009 SHALL have port io_out_valid, output, 1 bit: the registered output is valid toward the child datapath.
REQ-010 SHALL have port io_out_ready, input, 1 bit: the child accepts the beat.
REQ-011 SHALL have port io_out_bits, output, DATA_W bits: the registered payload.
REQ-012 SHALL have port io_out_src, output, clog2(N_REQ) bits: the index of the requester that sourced io_out_bits.
REQ-013 SHALL have port io_beat_count, output, 16 bits: the count of beats accepted on the output since reset.

Function
REQ-014 SHALL have a one-entry output register; can_load = !io_out_valid | io_out_ready.
REQ-015 SHALL assert io_in_ready[i] only for the single granted index, and only when can_load is 1; at most one bit may be high per cycle.
REQ-016 SHALL treat a transfer on input i as io_in_valid[i] & io_in_ready[i]; it loads io_out_bits/io_out_src on the next edge and sets io_out_valid (latency 1 cycle).
REQ-017 SHALL allow io_in_ready to depend combinationally on io_in_valid and io_out_ready; io_out_* SHALL be driven only from registers.
REQ-018 SHALL, in state ARB, grant the first valid requester at or after rr_ptr, searching upward with wrap N_REQ-1 -> 0.
REQ-019 SHALL, after a transfer from i with io_in_lock[i]=0, set rr_ptr = (i+1) mod N_REQ and remain in ARB.
REQ-020 SHALL, after a transfer from i with io_in_lock[i]=1, enter LOCKED with lock_id=i and leave rr_ptr unchanged.
REQ-021 SHALL, in LOCKED, grant only lock_id regardless of other valids, even if io_in_valid[lock_id]=0.
REQ-022 SHALL return from LOCKED to ARB after a lock_id transfer with io_in_lock[lock_id]=0, setting rr_ptr = (lock_id+1) mod N_REQ.
REQ-023 SHALL, on a simultaneous output drain and input load in one cycle, keep io_out_valid=1 with the new beat (no bubble).
REQ-024 SHALL clear io_out_valid on output drain when there is no input transfer.
REQ-025 SHALL hold io_out_bits and io_out_src stable while io_out_valid=1 and io_out_ready=0.
REQ-026 SHALL increment io_beat_count on each io_out_valid & io_out_ready, wrapping 0xFFFF -> 0x0000.
REQ-027 SHALL issue no grant in ARB when io_in_valid is all-zero; rr_ptr is unchanged.

Reset
REQ-028 SHALL, while reset=0, asynchronously force io_out_valid=0, io_out_bits=0, io_out_src=0, io_beat_count=0, rr_ptr=0, lock_id=0 and state=ARB.
REQ-029 SHALL drop any held beat and any active lock if reset is asserted mid-operation; io_in_ready SHALL be all-zero while reset=0.
REQ-030 SHALL deassert reset synchronously to clock externally; no internal synchronizer.

Structure
REQ-031 SHALL place DATA_W default, N_REQ default, the beat-counter width (16) and the state enum (ARB, LOCKED) in a shared package.
REQ-032 SHALL implement the rotate-and-priority search as one sub-module rr_pick (inputs: valid vector, pointer; outputs: one-hot grant, index, any).

Verification
REQ-033 SHALL cover: all 4 requesters valid continuously, io_out_ready=1 -> io_out_src sequence 0,1,2,3,0,...; one beat per cycle after the first.
REQ-034 SHALL cover: req 2 sends 0xA5A5A5A5 with lock=1, then 0x12345678 with lock=0, while req 0/1/3 are valid -> outputs from src 2, src 2, then src 3.
REQ-035 SHALL cover: io_out_ready=0 for 5 cycles with all valid -> io_out_bits stable, io_in_ready all-zero, no beat lost after release.
REQ-036 SHALL cover: reset pulsed low while LOCKED with io_out_valid=1 -> io_out_valid=0 at once; after release, a grant goes to req 0 first.
REQ-037 SHALL cover: 65537 output beats -> io_beat_count reads 0x0001.
